serial_mag_compare_ctrl: RTL and testbench
==========================================

Name: serial_mag_compare_ctrl

Overview:
- Sequencer that time-shares one comparator_1bit cell to compare two WIDTH-bit unsigned operands, scanning MSB-first, one bit per clock.
- Start/done handshake; early termination on the first differing bit.
- Area-cheap alternative to the parallel cascaded comparator, for wide operands where latency is acceptable.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2 to 64.
- EARLY_EXIT, 1, when 1 stop at the first differing bit; when 0 always scan all WIDTH bits. The result is identical either way.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- abort  input  1  synchronous cancel of an in-flight compare
- a  input  WIDTH  operand A; captured on the accepted start
- b  input  WIDTH  operand B; captured on the accepted start
- busy  output  1  high while in SCAN
- done  output  1  one-cycle pulse when the result becomes valid
- a_gt_b  output  1  registered result: A > B
- a_eq_b  output  1  registered result: A == B
- a_lt_b  output  1  registered result: A < B

Behaviour:
- States: IDLE, SCAN, DONE. Encoding is 2 bits, from the package.
- Reset (rst_n=0, async):
  - state=IDLE, idx=WIDTH-1, operand registers=0.
  - busy=0, done=0, a_gt_b=0, a_eq_b=0, a_lt_b=0.
- IDLE:
  - start=1 at an edge: capture a and b into a_r and b_r, set idx=WIDTH-1, clear all three results to 0, go to SCAN.
  - start=0: remain in IDLE.
- SCAN, at each edge:
  - Feed a_r[idx] and b_r[idx] to the comparator_1bit instance.
  - abort=1 has priority over everything else: go to IDLE, results stay 0, no done pulse.
  - Bit gt (EARLY_EXIT=1): a_gt_b<=1, go to DONE.
  - Bit lt (EARLY_EXIT=1): a_lt_b<=1, go to DONE.
  - Bit eq and idx==0: a_eq_b<=1, go to DONE.
  - Otherwise: idx<=idx-1.
- EARLY_EXIT=0: the first inequality is latched into a sticky decided flag. Lower bits are ignored and the scan always runs to idx==0. The result written on that edge is the flag, or eq if no inequality was seen.
- DONE:
  - done=1 for exactly one cycle, then go unconditionally to IDLE.
  - start is ignored while in DONE.
- busy=1 exactly while state==SCAN.
- start while busy or in DONE is ignored. It is not queued.
- Results are held stable after DONE until the next accepted start clears them.
- Exactly one of gt/eq/lt is high after done; all are 0 during SCAN and after an abort.
- Latency, counting the start edge as edge 0:
  - EARLY_EXIT=1: the decision is made at edge k+1, where k = number of leading equal bits; done is high in the cycle after that edge.
  - EARLY_EXIT=0: the decision is always at edge WIDTH.
- Operand inputs a and b may change freely after the start edge; only the captured copies are used.
- idx is $clog2(WIDTH) bits wide and never decrements below 0.
- rst_n asserted mid-scan: immediate return to the reset values, and no done pulse.

Decomposition:
- Package serial_cmp_pkg holds:
  - state localparams: ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2;
  - the result one-hot encoding (GT/EQ/LT bit positions).
- One sub-module: comparator_1bit (ports a, b, gt, eq, lt; purely combinational).
- It is instantiated exactly once; the controller holds all state.

Test Plan:
- Reset checks:
  - Reset: hold rst_n=0 while start=1 -> all outputs 0, state IDLE.
  - Release reset and idle with start=0 -> nothing changes.
- WIDTH=8, EARLY_EXIT=1, a=8'hA5, b=8'h25, start pulse -> MSB differs; done one cycle after edge 1; a_gt_b=1, eq=lt=0; busy high for 1 cycle.
- WIDTH=8, a=8'h3C, b=8'h3C -> busy for 8 cycles; done after edge 8; a_eq_b=1. Repeat with EARLY_EXIT=0 and a=8'h80, b=8'h00 -> still 8 SCAN cycles; a_gt_b=1.
- WIDTH=8, a=8'h10, b=8'h12 -> decision at bit 1, edge 7; a_lt_b=1. Change a/b during SCAN -> result unchanged.
- Abort behaviour:
  - Start a=8'h00, b=8'h00, assert abort on the 3rd SCAN cycle -> IDLE next edge, no done, results 0.
  - Start again with a=8'h01, b=8'h00 -> normal completion with a_gt_b=1.
- Exhaustive WIDTH=2 sweep:
  - All 16 a/b pairs checked against a reference model.
  - A second start pulse during busy and during DONE is ignored: the result matches the first operands, and only one done pulse is produced.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: the controller state
// encoding and the one-hot layout of the {gt, eq, lt} result.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int RES_LT = 0;
  localparam int RES_EQ = 1;
  localparam int RES_GT = 2;

  typedef logic [2:0] result_t;

  function automatic result_t pack_result(input logic gt, input logic eq, input logic lt);
    result_t r;
    r         = '0;
    r[RES_GT] = gt;
    r[RES_EQ] = eq;
    r[RES_LT] = lt;
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_compare_ctrl_comparator_1bit.sv
// Single-bit magnitude compare cell; the controller time-shares one instance
// across all operand bits.
module comparator_1bit (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a & ~b;
  assign eq = ~(a ^ b);
  assign lt = ~a & b;

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// MSB-first serial magnitude comparator: captures two operands on start, feeds
// one bit pair per clock to a shared 1-bit cell, and reports a registered result.
module serial_mag_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  result_t          res;
  logic             decided;
  result_t          dec_res;

  logic bit_gt;
  logic bit_eq;
  logic bit_lt;

  comparator_1bit u_cmp (
    .a  (a_r[idx]),
    .b  (b_r[idx]),
    .gt (bit_gt),
    .eq (bit_eq),
    .lt (bit_lt)
  );

  // NOTE: every state update below uses <=, so all branches see pre-edge values
  // and the order of assignments within the block does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= IDX_MSB;
      a_r     <= '0;
      b_r     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      res     <= '0;
      decided <= 1'b0;
      dec_res <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            idx     <= IDX_MSB;
            res     <= '0;
            decided <= 1'b0;
            dec_res <= '0;
            busy    <= 1'b1;
            state   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (EARLY_EXIT && !bit_eq) begin
            res   <= pack_result(bit_gt, 1'b0, bit_lt);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (idx == '0) begin
            // Full-scan mode: the first inequality seen outranks the LSB compare.
            res   <= (!EARLY_EXIT && decided) ? dec_res
                                              : pack_result(bit_gt, bit_eq, bit_lt);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            idx <= idx - 1'b1;
            if (!decided && !bit_eq) begin
              decided <= 1'b1;
              dec_res <= pack_result(bit_gt, 1'b0, bit_lt);
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_gt_b = res[RES_GT];
  assign a_eq_b = res[RES_EQ];
  assign a_lt_b = res[RES_LT];

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Self-checking bench: three comparator configurations driven by directed and
// random operands, checked against an arithmetic reference of result and latency.
module tb_serial_mag_compare_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s [3];
  logic        abort_s [3];
  logic [63:0] a_s     [3];
  logic [63:0] b_s     [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic        gt_o    [3];
  logic        eq_o    [3];
  logic        lt_o    [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // 0: WIDTH=8 early exit, 1: WIDTH=8 full scan, 2: WIDTH=2 early exit
  serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .a(a_s[0][7:0]), .b(b_s[0][7:0]), .busy(busy_o[0]), .done(done_o[0]),
    .a_gt_b(gt_o[0]), .a_eq_b(eq_o[0]), .a_lt_b(lt_o[0]));

  serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .a(a_s[1][7:0]), .b(b_s[1][7:0]), .busy(busy_o[1]), .done(done_o[1]),
    .a_gt_b(gt_o[1]), .a_eq_b(eq_o[1]), .a_lt_b(lt_o[1]));

  serial_mag_compare_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]),
    .a(a_s[2][1:0]), .b(b_s[2][1:0]), .busy(busy_o[2]), .done(done_o[2]),
    .a_gt_b(gt_o[2]), .a_eq_b(eq_o[2]), .a_lt_b(lt_o[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] outs(input int d);
    return {gt_o[d], eq_o[d], lt_o[d]};
  endfunction

  // Reference: result from plain arithmetic; latency from the highest differing bit.
  function automatic logic [2:0] ref_result(input logic [63:0] av, input logic [63:0] bv);
    return {av > bv, av == bv, av < bv};
  endfunction

  function automatic int ref_edges(input int w, input bit ee,
                                   input logic [63:0] av, input logic [63:0] bv);
    logic [63:0] x;
    int          msb;
    x   = av ^ bv;
    msb = -1;
    for (int i = 0; i < w; i++) if (x[i]) msb = i;
    if (!ee || msb < 0) return w;
    return w - msb;
  endfunction

  task automatic run_cmp(input int d, input int w, input bit ee,
                         input logic [63:0] av_in, input logic [63:0] bv_in,
                         input string tag);
    logic [63:0] m;
    logic [63:0] av;
    logic [63:0] bv;
    logic [2:0]  exp_res;
    int          exp_cyc;
    int          cyc;
    m       = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    av      = av_in & m;
    bv      = bv_in & m;
    exp_res = ref_result(av, bv);
    exp_cyc = ref_edges(w, ee, av, bv);

    @(negedge clk);
    a_s[d] = av; b_s[d] = bv; start_s[d] = 1'b1;
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
    a_s[d] = {$urandom, $urandom};
    b_s[d] = {$urandom, $urandom};
    @(negedge clk);
    check({tag, "_scan_res"}, 64'(outs(d)), 64'd0);
    cyc = 0;
    while (busy_o[d] && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_done"}, 64'(done_o[d]), 64'd1);
    check({tag, "_result"}, 64'(outs(d)), 64'(exp_res));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done_o[d]), 64'd0);
    check({tag, "_held"}, 64'(outs(d)), 64'(exp_res));
  endtask

  initial begin
    int          dones;
    logic [63:0] ra;
    logic [63:0] rb;

    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b1; abort_s[d] = 1'b0; a_s[d] = '1; b_s[d] = '0;
    end

    // Reset held with start asserted: everything stays quiet.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("reset_outs_%0d", d),
            {59'd0, busy_o[d], done_o[d], outs(d)}, 64'd0);
    for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("idle_outs_%0d", d),
            {59'd0, busy_o[d], done_o[d], outs(d)}, 64'd0);

    // Directed cases.
    run_cmp(0, 8, 1'b1, 64'hA5, 64'h25, "msb_gt");
    run_cmp(0, 8, 1'b1, 64'h3C, 64'h3C, "equal");
    run_cmp(1, 8, 1'b0, 64'h80, 64'h00, "full_scan_gt");
    run_cmp(1, 8, 1'b0, 64'h3C, 64'h3C, "full_scan_eq");
    run_cmp(1, 8, 1'b0, 64'h01, 64'h00, "full_scan_lsb");
    run_cmp(0, 8, 1'b1, 64'h10, 64'h12, "bit1_lt");

    // Abort on the third SCAN cycle.
    @(negedge clk);
    a_s[0] = 64'h00; b_s[0] = 64'h00; start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 64'(busy_o[0]), 64'd1);
    abort_s[0] = 1'b1;
    @(posedge clk);
    #1 abort_s[0] = 1'b0;
    @(negedge clk);
    check("abort_state", {61'd0, busy_o[0], done_o[0], 1'b0}, 64'd0);
    check("abort_results", 64'(outs(0)), 64'd0);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      dones += int'(done_o[0]);
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run_cmp(0, 8, 1'b1, 64'h01, 64'h00, "after_abort");

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    a_s[1] = 64'h55; b_s[1] = 64'h54; start_s[1] = 1'b1;
    @(posedge clk);
    #1 start_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midscan_reset", {59'd0, busy_o[1], done_o[1], outs(1)}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      dones += int'(done_o[1]);
    end
    check("midscan_reset_no_done", 64'(dones), 64'd0);

    // Exhaustive WIDTH=2 sweep.
    for (int i = 0; i < 16; i++)
      run_cmp(2, 2, 1'b1, 64'(i / 4), 64'(i % 4), $sformatf("w2_%0d", i));

    // Starts while busy and while in DONE are ignored.
    dones = 0;
    @(negedge clk);
    a_s[2] = 64'd1; b_s[2] = 64'd1; start_s[2] = 1'b1;
    @(posedge clk);
    #1 start_s[2] = 1'b0; a_s[2] = 64'd0; b_s[2] = 64'd3;
    @(negedge clk);
    start_s[2] = 1'b1;
    @(posedge clk);
    #1 start_s[2] = 1'b0;
    @(posedge clk);
    #1 start_s[2] = 1'b1;
    @(negedge clk);
    dones += int'(done_o[2]);
    @(posedge clk);
    #1 start_s[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      dones += int'(done_o[2]);
    end
    check("ignore_start_dones", 64'(dones), 64'd1);
    check("ignore_start_result", 64'(outs(2)), 64'(ref_result(64'd1, 64'd1)));
    check("ignore_start_idle", 64'(busy_o[2]), 64'd0);

    // Random operands on both WIDTH=8 configurations.
    for (int i = 0; i < 12; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = (i % 3 == 0) ? ra ^ 64'(1 << $urandom_range(0, 7)) : 64'($urandom_range(0, 255));
      run_cmp(0, 8, 1'b1, ra, rb, $sformatf("rnd_ee_%0d", i));
      run_cmp(1, 8, 1'b0, ra, rb, $sformatf("rnd_fs_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
